// File: rtl/lookahead_input_unit.sv
// Router input port: flit FIFO, per-packet switch-allocator request, and
// header routing-field rewrite with the lookahead direction for the next hop.
//
// state | meaning
// IDLE  | FIFO empty, or head flit is not a header (held, no request)
// HEAD  | head flit is a header; request its route, rewrite its routing field
// BODY  | packet in flight; request locked_route while flits are present
module lookahead_input_unit #(
    parameter int DEPTH   = 4,
    parameter int COORD_W = 3,
    parameter int FLIT_W  = 34
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_W-1:0]      data_in,
    input  logic                   valid_in,
    output logic                   ready_out,
    output logic [2*COORD_W-1:0]   destination,
    output logic [4:0]             current_routing,
    input  logic [4:0]             next_routing,
    output logic [4:0]             request,
    input  logic                   grant,
    output logic [FLIT_W-1:0]      data_out,
    output logic                   valid_out
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int HDR_B  = FLIT_W - 1;
    localparam int TAIL_B = FLIT_W - 2;
    localparam int RT_HI  = FLIT_W - 3;
    localparam int DST_HI = FLIT_W - 8;

    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    logic [FLIT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0]  count, count_nx;
    state_t            state, state_nx;
    logic [4:0]        locked_route;
    logic [FLIT_W-1:0] head_flit;
    logic              push, pop;
    logic              nxt_is_hdr;

    assign head_flit       = mem[rd_ptr];
    assign valid_out       = (count != '0);
    assign ready_out       = (count != CNT_W'(DEPTH));
    assign push            = valid_in && ready_out;
    // Grants with nothing requested are ignored rather than popping.
    assign pop             = grant && valid_out && (request != '0);
    assign current_routing = valid_out ? head_flit[RT_HI -: 5] : '0;
    assign destination     = valid_out ? head_flit[DST_HI -: 2*COORD_W] : '0;
    assign rd_ptr_nx       = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

    // Request decode from the registered state; malformed routes never leak out.
    always_comb begin
        request = '0;
        case (state)
            HEAD:    request = $onehot(current_routing) ? current_routing : '0;
            BODY:    request = valid_out ? locked_route : '0;
            default: request = '0;
        endcase
    end

    // Only the header of a packet gets its routing field replaced.
    always_comb begin
        data_out = valid_out ? head_flit : '0;
        if (state == HEAD)
            data_out[RT_HI -: 5] = next_routing;
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        case ({push, pop})
            2'b10:   count_nx = count + CNT_W'(1);
            2'b01:   count_nx = count - CNT_W'(1);
            default: count_nx = count;
        endcase
    end

    // Whether the flit at the head next cycle is a header; a flit written this
    // cycle into the next head slot has not reached the memory yet.
    always_comb begin
        if (count_nx == '0)
            nxt_is_hdr = 1'b0;
        else if (push && (wr_ptr == rd_ptr_nx))
            nxt_is_hdr = data_in[HDR_B];
        else
            nxt_is_hdr = mem[rd_ptr_nx][HDR_B];
    end

    // Next state looks ahead at the next head flit so HEAD is valid on arrival.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = nxt_is_hdr ? HEAD : IDLE;
            HEAD: begin
                if (pop) begin
                    if (head_flit[TAIL_B]) state_nx = nxt_is_hdr ? HEAD : IDLE;
                    else                   state_nx = BODY;
                end
            end
            BODY: begin
                if (pop && head_flit[TAIL_B])
                    state_nx = nxt_is_hdr ? HEAD : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Flit storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_ptr_nx;
            count  <= count_nx;
        end
    end

    // Packet FSM and route lock taken when a multi-flit header leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            locked_route <= '0;
        end else begin
            state <= state_nx;
            if (state == HEAD && pop && !head_flit[TAIL_B])
                locked_route <= request;
        end
    end

endmodule
